seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a common-anode bank of DIGITS seven-segment indicators. Hex digits, decimal points and per-digit blanking are loaded through a strobe into a pending buffer and committed at a frame boundary, so a display never shows a torn value. The driver scans one digit per slot and emits registered segment and anode lines straight to board pins. It is the scanning successor to the single-digit hex decoder and contains the same glyph table internally.

## Interface
- DIGITS, 4, number of indicators scanned; legal range 1..8
- CLK_DIV, 50000, clk cycles per digit slot; must be at least 2
- ACTIVE_LOW, 1, 1 means seg, dp and an are active-low; 0 means all three are inverted to active-high

- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- dig_in  in  4*DIGITS  hex value per digit; digit k is in bits [4k+3:4k]; digit 0 is rightmost
- dp_in  in  DIGITS  decimal point request per digit
- blank_in  in  DIGITS  forces digit k fully dark
- lz_en  in  1  leading-zero suppression; sampled live, not buffered
- load  in  1  one-cycle strobe that captures dig_in, dp_in and blank_in into the pending buffer
- seg  out  7  gfedcba segment lines
- dp  out  1  decimal point line
- an  out  DIGITS  one-hot digit enable
- upd_done  out  1  one-cycle pulse when pending data becomes active

## Operation
- **Prescaler.** pcnt counts 0..CLK_DIV-1 and wraps. tick = (pcnt == CLK_DIV-1).
- **Scan index.** idx increments on tick, modulo DIGITS. frame_end = tick && idx == DIGITS-1. With DIGITS=1, idx stays 0 and every tick is a frame_end.
- **Buffers.** Two register sets, pending and active, each holding dig, dp and blank. A pend flag marks pending as valid.
  - load: pending <= inputs; pend <= 1. A second load before commit overwrites pending; the latest load wins.
  - frame_end && pend: active <= pending; pend <= 0; upd_done pulses on the next cycle.
  - load and commit on the same edge: active takes the old pending; pending takes the new inputs; pend stays 1.
- **Leading-zero suppression.** Digit k is suppressed when all of the following hold:
  - lz_en = 1 and k > 0;
  - active dig[k] = 0 and dp[k] = 0;
  - every digit j > k is blank, suppressed, or equal to 0 with no dp.
  - Digit 0 is never suppressed.
- **Glyph table** (gfedcba, lit = 0 before polarity):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Output stage** for current digit k:
  - an = one-hot on bit k.
  - seg = glyph(active dig[k]), or 1111111 if blank[k] or suppressed.
  - dp = lit iff dp[k] and not blank[k].
  - When ACTIVE_LOW = 0, seg, dp and an are all bitwise inverted.

## Timing
- **Reset (synchronous).** On the first edge with rst high:
  - pcnt = 0, idx = 0, pend = 0, upd_done = 0;
  - active and pending dig = 0, dp = 0, blank = all ones;
  - an = all inactive, seg = all off, dp = off.
- **Mid-operation reset.** rst mid-operation discards pending and any in-flight commit; no upd_done pulse is produced.
- **Output latency.** seg, dp and an are registered and lag idx and the active buffer by exactly 1 clk. Digit k is therefore driven for CLK_DIV consecutive cycles.
- **Frame period.** DIGITS*CLK_DIV cycles.
- **Commit latency.** Worst case from a load strobe to its data on slot-0 outputs is DIGITS*CLK_DIV + 1 cycles. upd_done rises in the same cycle that slot-0 outputs first show the new data.
- **Anode timing.** an changes only on the cycle after a tick, and exactly one bit is active at any time after the first post-reset output cycle.
- **Inputs.** dig_in, dp_in and blank_in are don't-care except on load cycles.

## Test plan
Unless stated otherwise: DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1.
- **Reset.** Assert rst for 2 cycles -> an=1111, seg=1111111, dp=1; upd_done never pulses; an scans 1110, 1101, 1011, 0111 every 4 cycles with seg dark.
- **Load and commit.** load dig_in=16'hA5C0, blank_in=0, dp_in=0010 -> upd_done pulse after the next frame_end. Slots then show C0/1000000 for digit 0, 1000110 with dp=0 for digit 1, 0010010 for digit 2, 0001000 for digit 3.
- **Leading zeros.** lz_en=1, load dig_in=16'h0007 -> digits 3..1 show 1111111 and digit 0 shows 1111000. Then load 16'h0000 -> only digit 0 is lit, showing 1000000.
- **Load collisions.** Two loads, 16'h1111 then 16'h2222, within one frame -> a single upd_done; display shows 2 (0100100). A load on the exact frame_end cycle -> the old pending commits, the new value commits one frame later, and each commit gives its own upd_done.
- **Polarity and width.** ACTIVE_LOW=0, DIGITS=1, CLK_DIV=2 -> an is constantly 1 after the first tick. Loading 8 -> seg=1111111 and upd_done rises within 3 cycles.
- **Mid-frame reset.** rst asserted with pend=1 -> outputs return to reset values next cycle, no upd_done, and the pending value is never shown.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Digit data is loaded into a
// pending buffer and swapped into the active buffer at a frame boundary, so a
// frame never mixes old and new digits. Segment, decimal point and anode lines
// are registered so they can go straight to board pins.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   dig_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  upd_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    // Dark levels depend on pin polarity.
    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic              DP_OFF  = ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tick, frameEnd, commit;

    logic [4*DIGITS-1:0]   pendDig_q, actDig_q;
    logic [DIGITS-1:0]     pendDp_q, actDp_q;
    logic [DIGITS-1:0]     pendBlank_q, actBlank_q;
    logic                  pend_q;
    logic                  commit_q;
    logic                  updDone_q;

    logic [DIGITS-1:0]     supp;
    logic                  allAbove;
    logic                  isZero;
    logic [3:0]            curDig;
    logic                  curDark;
    logic [6:0]            segLow;
    logic                  dpLow;
    logic [DIGITS-1:0]     anOneHot;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;

    // Glyph table in gfedcba order, a lit segment is 0.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Prescaler and scan index advance; a commit happens only at the end of a frame.
    always_comb begin
        tick     = (pcnt_q == PCNT_MAX);
        frameEnd = tick && (idx_q == IDX_MAX);
        commit   = frameEnd && pend_q;
        pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
    end

    // Leading-zero suppression walks from the most significant digit downwards;
    // a digit can only vanish if everything above it is already dark or zero.
    always_comb begin
        supp     = '0;
        allAbove = 1'b1;
        isZero   = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            isZero = (actDig_q[4*k +: 4] == 4'h0) && !actDp_q[k];
            if (lz_en && (k > 0) && isZero && allAbove) begin
                supp[k] = 1'b1;
            end
            allAbove = allAbove && (actBlank_q[k] || isZero);
        end
    end

    // Next values for the pin registers, built active-low and flipped if needed.
    always_comb begin
        curDig   = actDig_q[idx_q*4 +: 4];
        curDark  = actBlank_q[idx_q] || supp[idx_q];
        segLow   = curDark ? 7'b1111111 : glyph(curDig);
        dpLow    = !(actDp_q[idx_q] && !actBlank_q[idx_q]);
        anOneHot = '0;
        anOneHot[idx_q] = 1'b1;
        seg_d    = ACTIVE_LOW ? segLow : ~segLow;
        dp_d     = ACTIVE_LOW ? dpLow : ~dpLow;
        an_d     = ACTIVE_LOW ? ~anOneHot : anOneHot;
    end

    // All state: scan counters, the two buffers, the commit pipeline and the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            pendDig_q   <= '0;
            pendDp_q    <= '0;
            pendBlank_q <= '1;
            actDig_q    <= '0;
            actDp_q     <= '0;
            actBlank_q  <= '1;
            pend_q      <= 1'b0;
            commit_q    <= 1'b0;
            updDone_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            an_q        <= AN_OFF;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            commit_q  <= commit;
            updDone_q <= commit_q;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            if (commit) begin
                actDig_q   <= pendDig_q;
                actDp_q    <= pendDp_q;
                actBlank_q <= pendBlank_q;
            end
            if (load) begin
                pendDig_q   <= dig_in;
                pendDp_q    <= dp_in;
                pendBlank_q <= blank_in;
                pend_q      <= 1'b1;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign upd_done = updDone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit active-low instance and a
// 1-digit active-high instance share one clock.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digIn;
    logic [3:0]  dpIn, blankIn;
    logic        lzEn, load;
    logic [6:0]  seg;
    logic        dpOut;
    logic [3:0]  an;
    logic        updDone;

    logic [3:0]  digIn1;
    logic        dpIn1, blankIn1, lzEn1, load1;
    logic [6:0]  seg1;
    logic        dpOut1;
    logic [0:0]  an1;
    logic        updDone1;

    int testsRun = 0;
    int testsFailed = 0;

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1'b1)) u0 (
        .clk(clk), .rst(rst), .dig_in(digIn), .dp_in(dpIn), .blank_in(blankIn),
        .lz_en(lzEn), .load(load), .seg(seg), .dp(dpOut), .an(an), .upd_done(updDone)
    );

    seg7_scan_driver #(.DIGITS(1), .CLK_DIV(2), .ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .rst(rst), .dig_in(digIn1), .dp_in(dpIn1), .blank_in(blankIn1),
        .lz_en(lzEn1), .load(load1), .seg(seg1), .dp(dpOut1), .an(an1), .upd_done(updDone1)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv,
                                 input logic [3:0] bl);
        digIn   = d;
        dpIn    = dpv;
        blankIn = bl;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
    endtask

    task automatic waitUpd(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            if (updDone === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, {31'b0, seen}, 32'd1);
    endtask

    task automatic waitSlot(input int k, input string tag);
        bit seen = 1'b0;
        logic [3:0] target;
        target = ~(4'b0001 << k);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (an === target) seen = 1'b1;
            else step(1);
        end
        checkOutput(tag, {31'b0, seen}, 32'd1);
    endtask

    task automatic countUpd(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (updDone === 1'b1) c++;
        end
    endtask

    initial begin
        int c;
        int cyc;
        bit seen;
        rst = 1'b1; load = 1'b0; lzEn = 1'b0;
        digIn = '0; dpIn = '0; blankIn = '0;
        digIn1 = '0; dpIn1 = 1'b0; blankIn1 = 1'b0; lzEn1 = 1'b0; load1 = 1'b0;

        // Reset values
        step(2);
        checkOutput("rst_an", an, 4'hF);
        checkOutput("rst_seg", seg, 7'h7F);
        checkOutput("rst_dp", dpOut, 1'b1);
        checkOutput("rst_upd", updDone, 1'b0);
        checkOutput("rst_an1", an1, 1'b0);
        checkOutput("rst_seg1", seg1, 7'h00);
        checkOutput("rst_dp1", dpOut1, 1'b0);
        rst = 1'b0;

        // Dark scan after reset
        step(1);
        checkOutput("scan0_an", an, 4'hE);
        checkOutput("scan0_seg", seg, 7'h7F);
        checkOutput("an1_on", an1, 1'b1);
        checkOutput("seg1_dark", seg1, 7'h00);
        step(3);
        checkOutput("scan0_last", an, 4'hE);
        step(1);
        checkOutput("scan1_an", an, 4'hD);
        step(4);
        checkOutput("scan2_an", an, 4'hB);
        step(4);
        checkOutput("scan3_an", an, 4'h7);
        checkOutput("scan3_seg", seg, 7'h7F);
        checkOutput("scan_upd", updDone, 1'b0);

        // Load and commit, exact latency to the frame boundary
        applyStimulus(16'hA5C0, 4'b0010, 4'b0000);
        step(2);
        checkOutput("commit_early", updDone, 1'b0);
        step(1);
        checkOutput("commit_upd", updDone, 1'b1);
        checkOutput("commit_an", an, 4'hE);
        checkOutput("commit_seg0", seg, 7'h40);
        checkOutput("commit_dp0", dpOut, 1'b1);
        step(1);
        checkOutput("commit_pulse", updDone, 1'b0);
        waitSlot(1, "sync1");
        checkOutput("d1_seg", seg, 7'h46);
        checkOutput("d1_dp", dpOut, 1'b0);
        waitSlot(2, "sync2");
        checkOutput("d2_seg", seg, 7'h12);
        checkOutput("d2_dp", dpOut, 1'b1);
        waitSlot(3, "sync3");
        checkOutput("d3_seg", seg, 7'h08);

        // Leading-zero suppression
        lzEn = 1'b1;
        applyStimulus(16'h0007, 4'b0000, 4'b0000);
        waitUpd("lz7_upd");
        checkOutput("lz7_d0", seg, 7'h78);
        for (int k = 1; k < 4; k++) begin
            waitSlot(k, "lz7_sync");
            checkOutput($sformatf("lz7_d%0d", k), seg, 7'h7F);
        end
        applyStimulus(16'h0000, 4'b0000, 4'b0000);
        waitUpd("lz0_upd");
        checkOutput("lz0_d0", seg, 7'h40);
        waitSlot(3, "lz0_sync");
        checkOutput("lz0_d3", seg, 7'h7F);
        lzEn = 1'b0;
        step(1);
        checkOutput("lz_live_d3", seg, 7'h40);
        lzEn = 1'b1;

        applyStimulus(16'h0102, 4'b0000, 4'b0000);
        waitUpd("lzmid_upd");
        checkOutput("lzmid_d0", seg, 7'h24);
        waitSlot(1, "lzmid_s1");
        checkOutput("lzmid_d1", seg, 7'h40);
        waitSlot(2, "lzmid_s2");
        checkOutput("lzmid_d2", seg, 7'h79);
        waitSlot(3, "lzmid_s3");
        checkOutput("lzmid_d3", seg, 7'h7F);

        applyStimulus(16'h0500, 4'b0000, 4'b0100);
        waitUpd("lzblk_upd");
        checkOutput("lzblk_d0", seg, 7'h40);
        waitSlot(1, "lzblk_s1");
        checkOutput("lzblk_d1", seg, 7'h7F);
        waitSlot(2, "lzblk_s2");
        checkOutput("lzblk_d2", seg, 7'h7F);
        checkOutput("lzblk_dp2", dpOut, 1'b1);

        applyStimulus(16'h0000, 4'b0100, 4'b0000);
        waitUpd("lzdp_upd");
        waitSlot(1, "lzdp_s1");
        checkOutput("lzdp_d1", seg, 7'h40);
        waitSlot(2, "lzdp_s2");
        checkOutput("lzdp_d2", seg, 7'h40);
        checkOutput("lzdp_dp2", dpOut, 1'b0);
        waitSlot(3, "lzdp_s3");
        checkOutput("lzdp_d3", seg, 7'h7F);
        lzEn = 1'b0;

        // Two loads within one frame: latest wins, one commit
        waitSlot(1, "coll_sync");
        applyStimulus(16'h1111, 4'b0000, 4'b0000);
        applyStimulus(16'h2222, 4'b0000, 4'b0000);
        countUpd(40, c);
        checkOutput("coll_upd_count", c, 32'd1);
        waitSlot(0, "coll_s0");
        checkOutput("coll_seg", seg, 7'h24);

        // Load exactly on the frame_end edge
        applyStimulus(16'h9999, 4'b0000, 4'b0000);
        waitUpd("fe_sync");
        applyStimulus(16'h3333, 4'b0000, 4'b0000);
        step(13);
        applyStimulus(16'h4444, 4'b0000, 4'b0000);
        step(1);
        checkOutput("fe_upd1", updDone, 1'b1);
        checkOutput("fe_seg1", seg, 7'h30);
        countUpd(15, c);
        checkOutput("fe_gap", c, 32'd0);
        step(1);
        checkOutput("fe_upd2", updDone, 1'b1);
        checkOutput("fe_seg2", seg, 7'h19);

        // Mid-frame reset with pending data
        waitSlot(1, "mrst_sync");
        applyStimulus(16'h5555, 4'b0000, 4'b0000);
        rst = 1'b1;
        step(1);
        checkOutput("mrst_an", an, 4'hF);
        checkOutput("mrst_seg", seg, 7'h7F);
        checkOutput("mrst_dp", dpOut, 1'b1);
        checkOutput("mrst_upd", updDone, 1'b0);
        rst = 1'b0;
        countUpd(40, c);
        checkOutput("mrst_no_upd", c, 32'd0);
        waitSlot(0, "mrst_s0");
        checkOutput("mrst_d0", seg, 7'h7F);

        // Single-digit active-high instance
        digIn1 = 4'h8; dpIn1 = 1'b0; blankIn1 = 1'b0; load1 = 1'b1;
        step(1);
        load1 = 1'b0;
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            if (updDone1 === 1'b1) seen = 1'b1;
            else begin step(1); cyc++; end
        end
        if (!seen && updDone1 === 1'b1) seen = 1'b1;
        checkOutput("w1_upd", {31'b0, seen}, 32'd1);
        checkOutput("w1_seg8", seg1, 7'h7F);
        checkOutput("w1_an", an1, 1'b1);
        checkOutput("w1_dp", dpOut1, 1'b0);
        lzEn1 = 1'b1;
        digIn1 = 4'h0; dpIn1 = 1'b1; load1 = 1'b1;
        step(1);
        load1 = 1'b0;
        step(4);
        checkOutput("w1_lz_seg0", seg1, 7'h3F);
        checkOutput("w1_dp_on", dpOut1, 1'b1);
        checkOutput("w1_an_hold", an1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
